// File: rtl/cam_tx_pkg.sv
// Shared encodings for the synthetic camera frame source: timing states,
// pattern-select codes and the RGB565 colour-bar palette.
package cam_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_CHECKER = 2'd3
    } pat_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Bar colours run left to right in index order.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] colour;
        colour = BAR_BLACK;
        case (idx)
            3'd0: colour = BAR_WHITE;
            3'd1: colour = BAR_YELLOW;
            3'd2: colour = BAR_CYAN;
            3'd3: colour = BAR_GREEN;
            3'd4: colour = BAR_MAGENTA;
            3'd5: colour = BAR_RED;
            3'd6: colour = BAR_BLUE;
            3'd7: colour = BAR_BLACK;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/cam_tx_pixgen.sv
// Combinational pixel generator: maps (x, y, bar index, pattern) to one RGB565 value.
module cam_tx_pixgen
    import cam_tx_pkg::*;
(
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  bar_idx,
    input  pat_e        pat,
    input  logic [15:0] solid,
    input  logic        frame_odd,
    output logic [15:0] pixel
);

    always_comb begin
        pixel = 16'h0000;
        case (pat)
            PAT_BARS:    pixel = bar_colour(bar_idx);
            PAT_RAMP:    pixel = {y, x};
            PAT_SOLID:   pixel = solid;
            PAT_CHECKER: pixel = (x[3] ^ y[3] ^ frame_odd) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/cam_frame_tx.sv
// Synthetic CMOS sensor: emits vsyn/href/RGB565 byte stream with deterministic test
// patterns, entirely in the pixel-clock domain. All outputs registered.
module cam_frame_tx
    import cam_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 17,
    parameter int V_FP        = 10
) (
    input  logic        cmos_pclk,
    input  logic        rst_133,
    input  logic        en_i,
    input  logic [1:0]  pat_sel_i,
    input  logic [15:0] solid_i,
    output logic        cmos_vsyn_o,
    output logic        cmos_href_o,
    output logic [7:0]  cmos_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);

    localparam int LINE_PCLK   = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BP + V_ACTIVE + V_FP;
    localparam int HW          = $clog2(LINE_PCLK);
    localparam int LW          = $clog2(FRAME_LINES);
    localparam int BAR_W       = H_ACTIVE / 8;

    tx_state_e     state, state_next;
    logic [HW-1:0] h_cnt;
    logic [LW-1:0] l_cnt, last_line;
    logic          line_end, state_end, frame_start, active_px;
    logic [15:0]   bar_cnt;
    logic [2:0]    bar_idx;
    pat_e          pat_q;
    logic [15:0]   solid_q, frame_cnt, pixel;
    logic          vsyn_d, href_d, busy_d, done_d;
    logic [7:0]    data_d;

    always_comb begin
        last_line = '0;
        case (state)
            ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
            ST_VBP:    last_line = LW'(V_BP - 1);
            ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
            ST_VFP:    last_line = LW'(V_FP - 1);
            default:   last_line = '0;
        endcase
    end

    assign line_end    = (h_cnt == HW'(LINE_PCLK - 1));
    assign state_end   = line_end && (l_cnt == last_line);
    assign frame_start = (state_next == ST_VSYNC) && (state != ST_VSYNC);
    assign active_px   = (state == ST_ACTIVE) && (h_cnt < HW'(2 * H_ACTIVE));

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) state <= ST_IDLE;
        else          state <= state_next;
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (en_i)      state_next = ST_VSYNC;
            ST_VSYNC:  if (state_end) state_next = ST_VBP;
            ST_VBP:    if (state_end) state_next = ST_ACTIVE;
            ST_ACTIVE: if (state_end) state_next = ST_VFP;
            ST_VFP:    if (state_end) state_next = en_i ? ST_VSYNC : ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // l_cnt counts lines within the current state and restarts on each state change.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            h_cnt <= '0;
            l_cnt <= '0;
        end else if (state == ST_IDLE) begin
            h_cnt <= '0;
            l_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            l_cnt <= state_end ? '0 : l_cnt + LW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Bar index steps every BAR_W pixels, counted on the low-byte cycle of each pixel.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (!active_px) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (h_cnt[0]) begin
            if (bar_cnt == 16'(BAR_W - 1)) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            pat_q     <= PAT_BARS;
            solid_q   <= '0;
            frame_cnt <= '0;
        end else begin
            if (frame_start) begin
                pat_q   <= pat_e'(pat_sel_i);
                solid_q <= solid_i;
            end
            if (done_d) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    cam_tx_pixgen u_pixgen (
        .x         (8'(h_cnt >> 1)),
        .y         (8'(l_cnt)),
        .bar_idx   (bar_idx),
        .pat       (pat_q),
        .solid     (solid_q),
        .frame_odd (frame_cnt[0]),
        .pixel     (pixel)
    );

    always_comb begin
        vsyn_d = (state == ST_VSYNC);
        href_d = active_px;
        busy_d = (state != ST_IDLE);
        done_d = (state == ST_VFP) && state_end;
        data_d = 8'h00;
        if (active_px) data_d = h_cnt[0] ? pixel[7:0] : pixel[15:8];
    end

    // frame_cnt_o trails the internal count by one edge, after the frame_done_o pulse.
    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            cmos_vsyn_o  <= 1'b0;
            cmos_href_o  <= 1'b0;
            cmos_data_o  <= 8'h00;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= 16'h0000;
        end else begin
            cmos_vsyn_o  <= vsyn_d;
            cmos_href_o  <= href_d;
            cmos_data_o  <= data_d;
            busy_o       <= busy_d;
            frame_done_o <= done_d;
            frame_cnt_o  <= frame_cnt;
        end
    end

endmodule
